// File: rtl/ifu_stream_fetch.sv
// Instruction-fetch unit: fully-associative line buffer, single-outstanding miss engine and
// optional next-line prefetcher (compiled in when IFU_PREFETCH_EN is defined).
module ifu_stream_fetch #(
   parameter  int ADDR_WIDTH   = 32,
   parameter  int LINE_WIDTH   = 128,
   parameter  int NUM_LINES    = 4,
   localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
   localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH
) (
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic                  cpu_reqValidIn,
   input  logic [ADDR_WIDTH-1:0] cpu_reqAddrIn,
   output logic [ADDR_WIDTH-1:0] cpu_rspAddrOut,
   output logic [LINE_WIDTH-1:0] cpu_rspInsLineOut,
   output logic                  cpu_rspInsLineValidOut,
   input  logic                  mem_reqReadyIn,
   output logic                  mem_reqValidOut,
   output logic [ADDR_WIDTH-1:0] mem_reqAddrOut,
   input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
   input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
   input  logic                  mem_rspValidIn,
   output logic [2:0]            dbg_state
);

   localparam int IDX_WIDTH = $clog2(NUM_LINES);

`ifdef IFU_PREFETCH_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_WAIT = 3'd2, ST_PF_REQ = 3'd3, ST_PF_WAIT = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_WAIT = 3'd2
   } state_t;
`endif

   // Memory handshake: a request transfers on a cycle with mem_reqValidOut && mem_reqReadyIn;
   // valid and address are held until then. Responses are single-cycle and tag-checked.
   state_t                 state;
   logic [NUM_LINES-1:0]   valid;
   logic [IDX_WIDTH-1:0]   victim;
   logic [TAG_WIDTH-1:0]   pend_tag;
   logic [TAG_WIDTH-1:0]   tag_mem  [NUM_LINES];
   logic [LINE_WIDTH-1:0]  data_mem [NUM_LINES];

   logic [TAG_WIDTH-1:0]   cpu_tag;
   logic                   hit;
   logic [IDX_WIDTH-1:0]   hit_idx;
   logic                   accept;
   logic                   serve_hit;
   logic                   rsp_match;
   logic                   unused_offset;

   assign cpu_tag       = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH];
   assign unused_offset = ^cpu_reqAddrIn[OFFSET_WIDTH-1:0];
   assign dbg_state     = state;
   // The CPU still holds its request during the response pulse; do not serve it twice.
   assign accept        = cpu_reqValidIn && !cpu_rspInsLineValidOut;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (valid[i] && tag_mem[i] == cpu_tag) begin
            hit     = 1'b1;
            hit_idx = IDX_WIDTH'(i);
         end
      end
   end

`ifdef IFU_PREFETCH_EN
   logic [TAG_WIDTH-1:0] next_tag;
   logic                 next_present;

   assign next_tag = pend_tag + TAG_WIDTH'(1);

   // The slot about to be overwritten by the fill no longer counts as holding the next line.
   always_comb begin
      next_present = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (valid[i] && tag_mem[i] == next_tag && IDX_WIDTH'(i) != victim) next_present = 1'b1;
      end
   end

   assign serve_hit = accept && hit && (state == ST_IDLE || state == ST_PF_REQ || state == ST_PF_WAIT);
   assign rsp_match = mem_rspValidIn && mem_rspTagIn == pend_tag &&
                      (state == ST_WAIT || state == ST_PF_WAIT);
`else
   assign serve_hit = accept && hit && state == ST_IDLE;
   assign rsp_match = mem_rspValidIn && mem_rspTagIn == pend_tag && state == ST_WAIT;
`endif

   always_ff @(posedge Clock) begin
      if (rsp_match) begin
         tag_mem[victim]  <= mem_rspTagIn;
         data_mem[victim] <= mem_rspInsLineIn;
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state                  <= ST_IDLE;
         valid                  <= '0;
         victim                 <= '0;
         pend_tag               <= '0;
         cpu_rspAddrOut         <= '0;
         cpu_rspInsLineOut      <= '0;
         cpu_rspInsLineValidOut <= 1'b0;
         mem_reqValidOut        <= 1'b0;
         mem_reqAddrOut         <= '0;
      end else begin
         cpu_rspInsLineValidOut <= 1'b0;
         if (rsp_match) begin
            valid[victim] <= 1'b1;
            victim        <= victim + IDX_WIDTH'(1);
         end
         if (serve_hit) begin
            cpu_rspInsLineValidOut <= 1'b1;
            cpu_rspAddrOut         <= {cpu_tag, {OFFSET_WIDTH{1'b0}}};
            cpu_rspInsLineOut      <= data_mem[hit_idx];
         end
         case (state)
            ST_IDLE: begin
               if (accept && !hit) begin
                  pend_tag        <= cpu_tag;
                  mem_reqValidOut <= 1'b1;
                  mem_reqAddrOut  <= {cpu_tag, {OFFSET_WIDTH{1'b0}}};
                  state           <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_reqReadyIn) begin
                  mem_reqValidOut <= 1'b0;
                  state           <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (rsp_match) begin
                  cpu_rspInsLineValidOut <= 1'b1;
                  cpu_rspAddrOut         <= {pend_tag, {OFFSET_WIDTH{1'b0}}};
                  cpu_rspInsLineOut      <= mem_rspInsLineIn;
`ifdef IFU_PREFETCH_EN
                  if (!next_present) begin
                     pend_tag        <= next_tag;
                     mem_reqValidOut <= 1'b1;
                     mem_reqAddrOut  <= {next_tag, {OFFSET_WIDTH{1'b0}}};
                     state           <= ST_PF_REQ;
                  end else begin
                     state <= ST_IDLE;
                  end
`else
                  state <= ST_IDLE;
`endif
               end
            end
`ifdef IFU_PREFETCH_EN
            ST_PF_REQ: begin
               if (mem_reqReadyIn) begin
                  mem_reqValidOut <= 1'b0;
                  state           <= ST_PF_WAIT;
               end
            end
            // Silent fill; a waiting miss is re-looked-up from IDLE afterwards.
            ST_PF_WAIT: begin
               if (rsp_match) state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
